// File: rtl/dataready_source.sv
// Producer side of the inputdata_ready / loaddata handshake: synchronizes and debounces a
// push-button, captures data_in per press. Optional macro LOADDATA_HANDSHAKE_EN enables loaddata handshake.
module dataready_source #(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLD_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES  = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             btn_press,
    input  logic [WIDTH-1:0] data_in,
    input  logic             loaddata,
    output logic [WIDTH-1:0] data_out,
    output logic             inputdata_ready,
    output logic             ack_timeout
);

    localparam int MAX_A = (DEBOUNCE_CYCLES > HOLD_CYCLES) ? DEBOUNCE_CYCLES : HOLD_CYCLES;
    localparam int MAX_P = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
    localparam int CNT_W = $clog2(MAX_P) + 1;

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        PRESENT  = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    state_t           state, state_nxt;
    logic [1:0]       sync_q;
    logic             btn_s;
    logic [CNT_W-1:0] cnt, cnt_nxt, cnt_inc;
    logic             capture;
    logic             ready_nxt;

    // Two-flop synchronizer; btn_s is the only view of the button the FSM gets.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= 2'b00;
        else       sync_q <= {sync_q[0], btn_press};
    end
    assign btn_s = sync_q[1];

    // Saturating increment so a long-held state can never wrap the counter.
    assign cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;

`ifdef LOADDATA_HANDSHAKE_EN
    logic ack_nxt;
    logic ack_q;
`else
    logic unused_loaddata;
    assign unused_loaddata = loaddata;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        capture   = 1'b0;
        ready_nxt = inputdata_ready;
`ifdef LOADDATA_HANDSHAKE_EN
        ack_nxt   = 1'b0;
`endif
        case (state)
            IDLE: begin
                ready_nxt = 1'b0;
                if (btn_s) begin
                    state_nxt = DEBOUNCE;
                    cnt_nxt   = '0;
                end
            end
            DEBOUNCE: begin
                if (!btn_s) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nxt = PRESENT;
                    cnt_nxt   = '0;
                    capture   = 1'b1;
                    ready_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            PRESENT: begin
                // btn_s is deliberately ignored here; release is qualified in RELEASE.
                ready_nxt = 1'b1;
`ifdef LOADDATA_HANDSHAKE_EN
                if (!loaddata) begin
                    state_nxt = RELEASE;
                    cnt_nxt   = '0;
                    ready_nxt = 1'b0;
                end else if (cnt == TO_LAST) begin
                    state_nxt = RELEASE;
                    cnt_nxt   = '0;
                    ready_nxt = 1'b0;
                    ack_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt_inc;
                end
`else
                if (cnt == HOLD_LAST) begin
                    state_nxt = RELEASE;
                    cnt_nxt   = '0;
                    ready_nxt = 1'b0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
`endif
            end
            RELEASE: begin
                ready_nxt = 1'b0;
                if (btn_s) begin
                    cnt_nxt = '0;
                end else if (cnt == DB_LAST) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt_inc;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                ready_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            cnt             <= '0;
            data_out        <= '0;
            inputdata_ready <= 1'b0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            inputdata_ready <= ready_nxt;
            if (capture) data_out <= data_in;
        end
    end

`ifdef LOADDATA_HANDSHAKE_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) ack_q <= 1'b0;
        else       ack_q <= ack_nxt;
    end
    assign ack_timeout = ack_q;
`else
    assign ack_timeout = 1'b0;
`endif

endmodule
